// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared RISC-V decode constants: major opcodes (inst[6:0]) and the
// immediate-format encoding carried on out_fmt.
// Ports: none (package).
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

endpackage

// File: rtl/imm_decode.sv
// imm_decode
// Purely combinational immediate extraction and format classification.
// Ports:
//   inst    in  32    raw instruction word
//   imm     out XLEN  sign-extended immediate (zero-extended for CSR zimm)
//   fmt     out 3     format code (fmt_e encoding)
//   illegal out 1     opcode not recognised for this XLEN
module imm_decode
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    localparam bit RV64 = (XLEN == 64);

    fmt_e        f;
    logic [31:0] imm32;

    // Every immediate is first built as a 32-bit sign-correct value; the
    // final widening to XLEN replicates bit 31 (zimm keeps bit 31 clear).
    always_comb begin
        imm32   = '0;
        f       = FMT_NONE;
        illegal = 1'b0;
        case (inst[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                f     = FMT_I;
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_OP_IMM_32: begin
                if (RV64) begin
                    f     = FMT_I;
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                f     = FMT_S;
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
                f     = FMT_B;
                imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                f     = FMT_U;
                imm32 = {inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                f     = FMT_J;
                imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
                if (inst[14]) begin
                    f     = FMT_Z;
                    imm32 = {27'b0, inst[19:15]};
                end else begin
                    f     = FMT_I;
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OPC_OP, OPC_MISC_MEM: begin
                f = FMT_NONE;
            end
            OPC_OP_32: begin
                illegal = !RV64;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = XLEN'($signed(imm32));
    assign fmt = f;

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage
// Registered immediate-generation stage: decodes each accepted instruction
// and holds the result in a 2-entry skid FIFO with valid/ready handshakes.
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   flush              drop all buffered entries and the same-cycle input
//   in_valid/in_ready  upstream handshake; in_inst/in_pc input payload
//   out_valid/out_ready downstream handshake
//   out_inst/out_pc    passthrough of the head entry
//   out_imm/out_fmt/out_illegal  decoded head entry (0 when empty)
module imm_gen_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [PC_W-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    typedef struct packed {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    entry_t          mem [2];
    entry_t          din;
    entry_t          head;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic [1:0]      cnt;
    logic            wr_ptr;
    logic            rd_ptr;
    logic            push;
    logic            pop;

    imm_decode #(.XLEN(XLEN)) u_imm_decode (
        .inst    (in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign din = '{inst: in_inst, pc: in_pc, imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal};

    assign in_ready  = (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            cnt    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: an entry is only observable once cnt covers it.
    always_ff @(posedge clk) begin
        if (rstn && push) mem[wr_ptr] <= din;
    end

    assign head = out_valid ? mem[rd_ptr] : '0;

    assign out_inst    = head.inst;
    assign out_pc      = head.pc;
    assign out_imm     = head.imm;
    assign out_fmt     = head.fmt;
    assign out_illegal = head.illegal;

endmodule
